// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: register/word types,
// MDU result bundle and pending-FIFO entry, plus a saturating counter helper.
package wb_port_arbiter_pkg;

    typedef logic [63:0] word_t;
    typedef logic [4:0]  creg_addr_t;

    typedef struct packed {
        creg_addr_t dst;
        word_t      data;
    } mdu_result_t;

    typedef struct packed {
        logic       valid;
        creg_addr_t dst;
        word_t      data;
    } wb_pend_entry_t;

    localparam creg_addr_t REG_ZERO = 5'd0;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// Circular FIFO of pending MDU results with per-entry squash-by-dst and
// per-entry destination match for the hazard-unit query.
module wb_pending_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  mdu_result_t      push_res_i,
    input  logic             pop_i,
    input  logic             squash_i,
    input  creg_addr_t       squash_dst_i,
    input  creg_addr_t       query_dst_i,
    output wb_pend_entry_t   head_o,
    output logic             empty_o,
    output logic             ready_o,
    output logic [DEPTH-1:0] squash_hit_o,
    output logic [DEPTH-1:0] query_hit_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wb_pend_entry_t   mem_q [DEPTH];
    wb_pend_entry_t   mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign head_o  = mem_q[head_q];
    assign empty_o = (count_q == '0);
    assign ready_o = (count_q < DEPTH_C);

    // Per-entry destination compares: squash hits and hazard query hits.
    always_comb begin
        squash_hit_o = '0;
        query_hit_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash_hit_o[i] = squash_i & mem_q[i].valid & (mem_q[i].dst == squash_dst_i);
            query_hit_o[i]  = mem_q[i].valid & (mem_q[i].dst == query_dst_i) & (query_dst_i != REG_ZERO);
        end
    end

    // Next-state: squash, then pop at head, then push at tail.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i].valid = mem_q[i].valid & ~squash_hit_o[i];
        end
        if (pop_i) begin
            mem_d[head_q].valid = 1'b0;
            head_d              = head_q + 1'b1;
        end else begin
            head_d = head_q;
        end
        if (push_i) begin
            mem_d[tail_q] = '{valid: 1'b1, dst: push_res_i.dst, data: push_res_i.data};
            tail_d        = tail_q + 1'b1;
        end else begin
            tail_d = tail_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback wins, MDU results queue and
// drain into idle cycles. Optional perf counters under WB_PORT_ARBITER_PERF_EN.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wb_valid_i,
    input  logic        wb_regwrite_i,
    input  logic [4:0]  wb_dst_i,
    input  logic [63:0] wb_wdata_i,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_dst_i,
    input  logic [63:0] mdu_data_i,
    output logic        mdu_ready_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [63:0] rf_wdata_o,
    output logic        stall_req_o,
    input  logic [4:0]  query_dst_i,
    output logic        query_pending_o
`ifdef WB_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_squash_cnt_o,
    output logic [31:0] perf_drain_cnt_o
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_LIMIT - 1);

    wb_pend_entry_t   head_s;
    mdu_result_t      mdu_res_s;
    logic             empty_s, ready_s;
    logic [DEPTH-1:0] squash_hit_s, query_hit_s;
    logic             pipe_we_s, drain_s, pop_s, accept_s, drop_s, push_s, blocked_s;
    logic             stall_q, stall_d;
    logic [SW-1:0]    starve_q, starve_d;

    assign mdu_res_s       = '{dst: mdu_dst_i, data: mdu_data_i};
    assign mdu_ready_o     = ready_s;
    assign stall_req_o     = stall_q;
    assign query_pending_o = |query_hit_s;

    // Port arbitration; a squashed head retires without touching the port.
    always_comb begin
        pipe_we_s = wb_valid_i & wb_regwrite_i & (wb_dst_i != REG_ZERO) & ~stall_q;
        drain_s   = ~pipe_we_s & head_s.valid;
        pop_s     = ~empty_s & (drain_s | ~head_s.valid);
        accept_s  = mdu_valid_i & ready_s;
        drop_s    = (mdu_dst_i == REG_ZERO) | (pipe_we_s & (mdu_dst_i == wb_dst_i));
        push_s    = accept_s & ~drop_s;
        blocked_s = head_s.valid & ~drain_s;
    end

    // Regfile write port mux.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = 64'd0;
        if (reset_i) begin
            rf_we_o = 1'b0;
        end else if (pipe_we_s) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_dst_i;
            rf_wdata_o = wb_wdata_i;
        end else if (drain_s) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = head_s.dst;
            rf_wdata_o = head_s.data;
        end else begin
            rf_we_o = 1'b0;
        end
    end

    // Starvation counter; the stall fires after STARVE_LIMIT blocked cycles.
    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (stall_q) begin
            starve_d = '0;
        end else if (blocked_s) begin
            starve_d = (starve_q == STARVE_MAX_C) ? starve_q + 1'b1 : starve_q + 1'b1;
            stall_d  = (starve_q == STARVE_MAX_C);
        end else begin
            starve_d = '0;
        end
    end

    // Starvation state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (push_s),
        .push_res_i   (mdu_res_s),
        .pop_i        (pop_s),
        .squash_i     (pipe_we_s),
        .squash_dst_i (wb_dst_i),
        .query_dst_i  (query_dst_i),
        .head_o       (head_s),
        .empty_o      (empty_s),
        .ready_o      (ready_s),
        .squash_hit_o (squash_hit_s),
        .query_hit_o  (query_hit_s)
    );

`ifdef WB_PORT_ARBITER_PERF_EN
    logic [31:0] stall_cnt_q, squash_cnt_q, drain_cnt_q;
    logic [31:0] squash_n_s;

    assign perf_stall_cnt_o  = stall_cnt_q;
    assign perf_squash_cnt_o = squash_cnt_q;
    assign perf_drain_cnt_o  = drain_cnt_q;

    // Squashed entries this cycle: stored hits plus a dropped incoming result.
    always_comb begin
        squash_n_s = {31'd0, accept_s & pipe_we_s & (mdu_dst_i == wb_dst_i)};
        for (int i = 0; i < DEPTH; i++) begin
            squash_n_s = squash_n_s + {31'd0, squash_hit_s[i]};
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q  <= 32'd0;
            squash_cnt_q <= 32'd0;
            drain_cnt_q  <= 32'd0;
        end else begin
            stall_cnt_q  <= sat_add32(stall_cnt_q, {31'd0, stall_q});
            squash_cnt_q <= sat_add32(squash_cnt_q, squash_n_s);
            drain_cnt_q  <= sat_add32(drain_cnt_q, {31'd0, drain_s});
        end
    end
`else
    logic perf_unused_s;
    assign perf_unused_s = ^squash_hit_s;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: per-cycle vector table, a queue
// scoreboard for MDU drain order, and a hand-written squash/starvation sequence.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset, wb_valid, wb_regwrite, mdu_valid;
    logic [4:0]  wb_dst, mdu_dst, query_dst, rf_waddr;
    logic [63:0] wb_wdata, mdu_data, rf_wdata;
    logic        mdu_ready, rf_we, stall_req, query_pending;
`ifdef WB_PORT_ARBITER_PERF_EN
    logic [31:0] perf_stall_cnt, perf_squash_cnt, perf_drain_cnt;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .wb_valid_i      (wb_valid),
        .wb_regwrite_i   (wb_regwrite),
        .wb_dst_i        (wb_dst),
        .wb_wdata_i      (wb_wdata),
        .mdu_valid_i     (mdu_valid),
        .mdu_dst_i       (mdu_dst),
        .mdu_data_i      (mdu_data),
        .mdu_ready_o     (mdu_ready),
        .rf_we_o         (rf_we),
        .rf_waddr_o      (rf_waddr),
        .rf_wdata_o      (rf_wdata),
        .stall_req_o     (stall_req),
        .query_dst_i     (query_dst),
        .query_pending_o (query_pending)
`ifdef WB_PORT_ARBITER_PERF_EN
        ,
        .perf_stall_cnt_o  (perf_stall_cnt),
        .perf_squash_cnt_o (perf_squash_cnt),
        .perf_drain_cnt_o  (perf_drain_cnt)
`endif
    );

    typedef struct packed {
        logic        rst;
        logic        wv;
        logic        wr;
        logic [4:0]  wd;
        logic [63:0] wdat;
        logic        mv;
        logic [4:0]  md;
        logic [63:0] mdat;
        logic [4:0]  qd;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        logic        e_rdy;
        logic        e_stl;
        logic        e_qp;
    } vec_t;

    vec_t        vecs [31];
    mdu_result_t sb_q [$];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int row);
        logic        pipe_b;
        mdu_result_t exp_r;
        reset       = v.rst;
        wb_valid    = v.wv;
        wb_regwrite = v.wr;
        wb_dst      = v.wd;
        wb_wdata    = v.wdat;
        mdu_valid   = v.mv;
        mdu_dst     = v.md;
        mdu_data    = v.mdat;
        query_dst   = v.qd;
        pipe_b = ~v.rst & v.wv & v.wr & (v.wd != 5'd0) & ~v.e_stl;
        @(negedge clk);
        chk("rf_we", row, 64'(rf_we), 64'(v.e_we));
        if (v.e_we) begin
            chk("rf_waddr", row, 64'(rf_waddr), 64'(v.e_wa));
            chk("rf_wdata", row, rf_wdata, v.e_wd);
        end
        chk("mdu_ready", row, 64'(mdu_ready), 64'(v.e_rdy));
        chk("stall_req", row, 64'(stall_req), 64'(v.e_stl));
        chk("query_pending", row, 64'(query_pending), 64'(v.e_qp));
        if (v.rst) begin
            sb_q.delete();
        end else begin
            if (rf_we && !pipe_b) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected row %0d: got write x%0d expected none", row, rf_waddr);
                end else begin
                    exp_r = sb_q.pop_front();
                    chk("sb_addr", row, 64'(rf_waddr), 64'(exp_r.dst));
                    chk("sb_data", row, rf_wdata, exp_r.data);
                end
            end
            if (pipe_b) begin
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    if (sb_q[i].dst == v.wd) sb_q.delete(i);
                end
            end
            if (v.mv && v.e_rdy && (v.md != 5'd0) && !(pipe_b && (v.md == v.wd))) begin
                sb_q.push_back('{dst: v.md, data: v.mdat});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst wv wr wd wdat | mv md mdat | qd | e_we e_wa e_wd e_rdy e_stl e_qp
        vecs[0]  = '{1'b1, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd0,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[1]  = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd7,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[2]  = '{1'b0, 1'b1,1'b1,5'd5,64'h11,    1'b0,5'd0,64'h0,      5'd7,  1'b1,5'd5,64'h11,    1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b0, 1'b1,1'b1,5'd0,64'h22,    1'b0,5'd0,64'h0,      5'd7,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0, 1'b1,1'b0,5'd3,64'h33,    1'b0,5'd0,64'h0,      5'd7,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[5]  = '{1'b0, 1'b1,1'b1,5'd3,64'h33,    1'b1,5'd7,64'hAA,     5'd7,  1'b1,5'd3,64'h33,    1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b0, 1'b1,1'b1,5'd4,64'h44,    1'b0,5'd0,64'h0,      5'd7,  1'b1,5'd4,64'h44,    1'b1,1'b0,1'b1};
        vecs[7]  = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd7,  1'b1,5'd7,64'hAA,    1'b1,1'b0,1'b1};
        vecs[8]  = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd7,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b1,5'd9,64'h99,     5'd9,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[10] = '{1'b0, 1'b1,1'b1,5'd9,64'h5,     1'b1,5'd9,64'h77,     5'd9,  1'b1,5'd9,64'h5,     1'b1,1'b0,1'b1};
        vecs[11] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd9,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[12] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd9,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b1,5'd0,64'hDEAD,   5'd0,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[14] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd0,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[15] = '{1'b0, 1'b1,1'b1,5'd1,64'h101,   1'b1,5'd10,64'hA0,    5'd10, 1'b1,5'd1,64'h101,   1'b1,1'b0,1'b0};
        vecs[16] = '{1'b0, 1'b1,1'b1,5'd2,64'h102,   1'b1,5'd11,64'hB0,    5'd10, 1'b1,5'd2,64'h102,   1'b1,1'b0,1'b1};
        vecs[17] = '{1'b0, 1'b1,1'b1,5'd1,64'h103,   1'b1,5'd12,64'hC0,    5'd11, 1'b1,5'd1,64'h103,   1'b0,1'b0,1'b1};
        vecs[18] = '{1'b0, 1'b1,1'b1,5'd2,64'h104,   1'b1,5'd12,64'hC0,    5'd12, 1'b1,5'd2,64'h104,   1'b0,1'b0,1'b0};
        vecs[19] = '{1'b0, 1'b1,1'b1,5'd1,64'h105,   1'b1,5'd12,64'hC0,    5'd10, 1'b1,5'd1,64'h105,   1'b0,1'b0,1'b1};
        vecs[20] = '{1'b0, 1'b1,1'b1,5'd2,64'h106,   1'b1,5'd12,64'hC0,    5'd10, 1'b1,5'd10,64'hA0,   1'b0,1'b1,1'b1};
        vecs[21] = '{1'b0, 1'b1,1'b1,5'd2,64'h106,   1'b1,5'd12,64'hC0,    5'd12, 1'b1,5'd2,64'h106,   1'b1,1'b0,1'b0};
        vecs[22] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd12, 1'b1,5'd11,64'hB0,   1'b0,1'b0,1'b1};
        vecs[23] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd12, 1'b1,5'd12,64'hC0,   1'b1,1'b0,1'b1};
        vecs[24] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd12, 1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[25] = '{1'b0, 1'b1,1'b1,5'd1,64'h107,   1'b1,5'd13,64'hD0,    5'd13, 1'b1,5'd1,64'h107,   1'b1,1'b0,1'b0};
        vecs[26] = '{1'b0, 1'b1,1'b1,5'd2,64'h108,   1'b1,5'd14,64'hE0,    5'd13, 1'b1,5'd2,64'h108,   1'b1,1'b0,1'b1};
        vecs[27] = '{1'b1, 1'b1,1'b1,5'd3,64'h109,   1'b0,5'd0,64'h0,      5'd0,  1'b0,5'd0,64'h0,     1'b0,1'b0,1'b0};
        vecs[28] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd13, 1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[29] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd14, 1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};
        vecs[30] = '{1'b0, 1'b0,1'b0,5'd0,64'h0,     1'b0,5'd0,64'h0,      5'd0,  1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0};

        reset = 1'b1; wb_valid = 1'b0; wb_regwrite = 1'b0; wb_dst = 5'd0; wb_wdata = 64'd0;
        mdu_valid = 1'b0; mdu_dst = 5'd0; mdu_data = 64'd0; query_dst = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 31; i++) begin
            apply_vec(vecs[i], i);
        end

`ifdef WB_PORT_ARBITER_PERF_EN
        chk("perf_stall_after_reset", 31, 64'(perf_stall_cnt), 64'd0);
        chk("perf_squash_after_reset", 31, 64'(perf_squash_cnt), 64'd0);
        chk("perf_drain_after_reset", 31, 64'(perf_drain_cnt), 64'd0);
`endif

        // Non-head squash while the full FIFO starves, then forced drain.
        apply_vec('{1'b0, 1'b1,1'b1,5'd1,64'h301,  1'b1,5'd20,64'h200, 5'd20, 1'b1,5'd1,64'h301,  1'b1,1'b0,1'b0}, 100);
        apply_vec('{1'b0, 1'b1,1'b1,5'd2,64'h302,  1'b1,5'd21,64'h201, 5'd20, 1'b1,5'd2,64'h302,  1'b1,1'b0,1'b1}, 101);
        apply_vec('{1'b0, 1'b1,1'b1,5'd21,64'h303, 1'b0,5'd0,64'h0,    5'd21, 1'b1,5'd21,64'h303, 1'b0,1'b0,1'b1}, 102);
        apply_vec('{1'b0, 1'b1,1'b1,5'd1,64'h304,  1'b0,5'd0,64'h0,    5'd21, 1'b1,5'd1,64'h304,  1'b0,1'b0,1'b0}, 103);
        apply_vec('{1'b0, 1'b1,1'b1,5'd2,64'h305,  1'b0,5'd0,64'h0,    5'd20, 1'b1,5'd2,64'h305,  1'b0,1'b0,1'b1}, 104);
        apply_vec('{1'b0, 1'b1,1'b1,5'd3,64'h306,  1'b0,5'd0,64'h0,    5'd20, 1'b1,5'd20,64'h200, 1'b0,1'b1,1'b1}, 105);
        apply_vec('{1'b0, 1'b1,1'b1,5'd3,64'h306,  1'b0,5'd0,64'h0,    5'd20, 1'b1,5'd3,64'h306,  1'b1,1'b0,1'b0}, 106);
        apply_vec('{1'b0, 1'b0,1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    5'd21, 1'b0,5'd0,64'h0,    1'b1,1'b0,1'b0}, 107);

`ifdef WB_PORT_ARBITER_PERF_EN
        chk("perf_stall", 108, 64'(perf_stall_cnt), 64'd1);
        chk("perf_squash", 108, 64'(perf_squash_cnt), 64'd1);
        chk("perf_drain", 108, 64'(perf_drain_cnt), 64'd1);
`endif

        chk("sb_leftover", 108, 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
